cnt_share_arb: RTL and testbench

Round-robin controller that shares one W-bit up-counter among NREQ requesters.
- Each requester asks for a run of len+1 counting cycles.
- The block grants one requester, loads and sequences the counter from 0 to that requester's terminal value, then pulses that requester's done and rotates priority.
- It sits between client FSMs and the free-running counter datapath and replaces ad-hoc per-client counters.

---
 rtl/cnt_share_arb_pkg.sv | 12 +
 rtl/cnt_share_arb_rr_pick.sv | 29 ++
 rtl/cnt_share_arb.sv | 108 ++++++++++
 tb/tb_cnt_share_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_share_arb_pkg.sv
// Shared types and default sizing for the counter-sharing round-robin arbiter.
package cnt_share_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned W_DEF    = 8;

endpackage

// File: rtl/cnt_share_arb_rr_pick.sv
// Rotating priority encoder: first set request scanning ptr, ptr+1, ... mod NREQ.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);

  always_comb begin
    int unsigned j;
    found  = 1'b0;
    onehot = '0;
    idx    = '0;
    j      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cnt_share_arb.sv
// Round-robin arbiter sharing one W-bit up-counter among NREQ requesters.
module cnt_share_arb
  import cnt_share_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned W    = W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic [W-1:0]    cnt_out,
  output logic [NREQ-1:0] done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n, owner, owner_n, owner_inc;
  logic [W-1:0]    term, term_n, cnt_n;
  logic [NREQ-1:0] gnt_n, done_n, owner_oh;
  logic            busy_n;

  logic            pick_found;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .found  (pick_found),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    owner_inc       = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    busy_n  = busy;
    cnt_n   = cnt_out;
    done_n  = '0;
    ptr_n   = ptr;
    owner_n = owner;
    term_n  = term;
    unique case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_n = ST_RUN;
          gnt_n   = pick_oh;
          busy_n  = 1'b1;
          owner_n = pick_idx;
          term_n  = len[int'(pick_idx)*W +: W];
          cnt_n   = '0;
        end
      end
      ST_RUN: begin
        // Abort outranks completion: a dropped request never earns a done pulse.
        if (!req[owner]) begin
          state_n = ST_IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          cnt_n   = '0;
          ptr_n   = owner_inc;
        end else if (cnt_out == term) begin
          state_n = ST_IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = owner_oh;
          ptr_n   = owner_inc;
        end else begin
          cnt_n = cnt_out + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      cnt_out <= '0;
      done    <= '0;
      ptr     <= '0;
      owner   <= '0;
      term    <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      busy    <= busy_n;
      cnt_out <= cnt_n;
      done    <= done_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      term    <= term_n;
    end
  end

endmodule

// File: tb/tb_cnt_share_arb.sv
// Directed self-checking bench for cnt_share_arb (NREQ=4, W=8).
module tb_cnt_share_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] len;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic [W-1:0]    cnt_out;
  logic [NREQ-1:0] done;

  int n_cmp  = 0;
  int n_fail = 0;
  bit running = 1'b0;

  cnt_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .len     (len),
    .gnt     (gnt),
    .busy    (busy),
    .cnt_out (cnt_out),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  // Structural invariants, checked every cycle away from the active edge.
  always @(negedge clk) begin
    if (running) begin
      n_cmp++;
      if (!$onehot0(gnt) || (busy !== |gnt) || ((done & gnt) !== '0)) begin
        n_fail++;
        $display("FAIL invariant: gnt=%b busy=%b done=%b", gnt, busy, done);
      end
    end
  end

  task automatic test_reset();
    len = '0;
    do_reset();
    tick();
    n_cmp++;
    if ({gnt, busy, cnt_out, done} !== {4'b0000, 1'b0, 8'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b busy=%b cnt=%0d done=%b want 0/0/0/0", gnt, busy, cnt_out, done);
    end
  endtask

  task automatic test_single_run();
    len[0*W +: W] = 8'd5;
    req = 4'b0001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || cnt_out !== 8'd0) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b busy=%b cnt=%0d want 0001/1/0", gnt, busy, cnt_out);
    end
    len[0*W +: W] = 8'd1;  // term latched at grant, must be ignored
    for (int v = 1; v <= 5; v++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0001 || cnt_out !== 8'(v) || done !== 4'b0000) begin
        n_fail++;
        $display("FAIL single_count: gnt=%b cnt=%0d done=%b want 0001/%0d/0000", gnt, cnt_out, done, v);
      end
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || done !== 4'b0001 || cnt_out !== 8'd5 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: gnt=%b done=%b cnt=%0d busy=%b want 0000/0001/5/0", gnt, done, cnt_out, busy);
    end
    req = '0;
    tick();
    n_cmp++;
    if (done !== 4'b0000 || cnt_out !== 8'd5 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_hold: done=%b cnt=%0d gnt=%b want 0000/5/0000", done, cnt_out, gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_oh;
    do_reset();
    for (int i = 0; i < NREQ; i++) len[i*W +: W] = 8'd2;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_oh = 4'b0001 << (g % NREQ);
      for (int v = 0; v <= 2; v++) begin
        tick();
        n_cmp++;
        if (gnt !== exp_oh || cnt_out !== 8'(v)) begin
          n_fail++;
          $display("FAIL rr_run%0d: gnt=%b cnt=%0d want %b/%0d", g, gnt, cnt_out, exp_oh, v);
        end
      end
      tick();
      n_cmp++;
      if (gnt !== 4'b0000 || done !== exp_oh) begin
        n_fail++;
        $display("FAIL rr_gap%0d: gnt=%b done=%b want 0000/%b", g, gnt, done, exp_oh);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_len_zero();
    // ptr=1 after the round-robin test ended on requester 0
    len[1*W +: W] = 8'd0;
    req = 4'b0010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || cnt_out !== 8'd0 || done !== 4'b0000) begin
      n_fail++;
      $display("FAIL len0_run: gnt=%b cnt=%0d done=%b want 0010/0/0000", gnt, cnt_out, done);
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || done !== 4'b0010 || cnt_out !== 8'd0) begin
      n_fail++;
      $display("FAIL len0_done: gnt=%b done=%b cnt=%0d want 0000/0010/0", gnt, done, cnt_out);
    end
    req = '0;
    tick();
  endtask

  task automatic test_len_max();
    int bad;
    bad = 0;
    len[2*W +: W] = 8'd255;
    req = 4'b0100;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || cnt_out !== 8'd0) begin
      n_fail++;
      $display("FAIL max_grant: gnt=%b cnt=%0d want 0100/0", gnt, cnt_out);
    end
    for (int v = 1; v <= 255; v++) begin
      tick();
      if (gnt !== 4'b0100 || cnt_out !== 8'(v)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL max_count: %0d bad cycles, last cnt=%0d gnt=%b want 255/0100", bad, cnt_out, gnt);
    end
    tick();
    n_cmp++;
    if (done !== 4'b0100 || cnt_out !== 8'd255 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL max_done: done=%b cnt=%0d gnt=%b want 0100/255/0000", done, cnt_out, gnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    len[0*W +: W] = 8'd0;
    req = 4'b0001;
    tick();
    tick();
    req = '0;
    tick();  // ptr now 1
    len[1*W +: W] = 8'd10;
    len[2*W +: W] = 8'd1;
    req = 4'b0110;
    for (int v = 0; v <= 3; v++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0010 || cnt_out !== 8'(v)) begin
        n_fail++;
        $display("FAIL abort_run: gnt=%b cnt=%0d want 0010/%0d", gnt, cnt_out, v);
      end
    end
    req = 4'b0100;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || cnt_out !== 8'd0 || done !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_drop: gnt=%b cnt=%0d done=%b busy=%b want 0000/0/0000/0", gnt, cnt_out, done, busy);
    end
    req = 4'b0110;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || cnt_out !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_next: gnt=%b cnt=%0d want 0100/0", gnt, cnt_out);
    end
    tick();
    tick();
    n_cmp++;
    if (done !== 4'b0100 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_next_done: done=%b gnt=%b want 0100/0000", done, gnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    // ptr=3 here; lone req0 still wins
    len[0*W +: W] = 8'd9;
    req = 4'b0001;
    for (int v = 0; v <= 4; v++) tick();
    n_cmp++;
    if (cnt_out !== 8'd4 || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_pre: cnt=%0d gnt=%b want 4/0001", cnt_out, gnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || cnt_out !== 8'd0 || done !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid: gnt=%b busy=%b cnt=%0d done=%b want 0000/0/0/0000", gnt, busy, cnt_out, done);
    end
    req = 4'b1001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || cnt_out !== 8'd0 || done !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_ptr: gnt=%b cnt=%0d done=%b want 0001/0/0000", gnt, cnt_out, done);
    end
    req = '0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    len = '0;
    tick();
    running = 1'b1;
    test_reset();
    test_single_run();
    test_round_robin();
    test_len_zero();
    test_len_max();
    test_abort();
    test_reset_mid_run();
    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
